// File: rtl/fb_scan_ctrl_pkg.sv
// Shared 640x480@60 video timing constants, pixel clock divider and scan FSM encoding.
package fb_scan_ctrl_pkg;

  localparam int   VID_CLK_DIV   = 5;
  localparam int   VID_H_ACTIVE  = 640;
  localparam int   VID_H_FP      = 16;
  localparam int   VID_H_SYNC    = 96;
  localparam int   VID_H_BP      = 48;
  localparam int   VID_V_ACTIVE  = 480;
  localparam int   VID_V_FP      = 10;
  localparam int   VID_V_SYNC    = 2;
  localparam int   VID_V_BP      = 33;
  localparam int   VID_IMG_LINES = 400;
  localparam logic VID_SYNC_POL  = 1'b0;
  localparam int   VID_AW        = 20;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_IDLE = 2'd0;
  localparam scan_state_t ST_ARM  = 2'd1;
  localparam scan_state_t ST_RUN  = 2'd2;

  // Half-open window test lo <= val < hi, used for sync pulse placement.
  function automatic logic in_window(input logic [15:0] val, input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/fb_scan_ctrl_vid_timing_cnt.sv
// Pixel-rate divider plus horizontal/vertical position counters with frame wrap pulse.
module fb_scan_ctrl_vid_timing_cnt
  import fb_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = VID_CLK_DIV,
  parameter int HT      = VID_H_ACTIVE + VID_H_FP + VID_H_SYNC + VID_H_BP,
  parameter int VT      = VID_V_ACTIVE + VID_V_FP + VID_V_SYNC + VID_V_BP,
  parameter int DW      = $clog2(CLK_DIV),
  parameter int HW      = $clog2(HT),
  parameter int VW      = $clog2(VT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  output logic [DW-1:0] o_div,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic          o_frame_wrap
);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_pix_step;
  logic          w_line_wrap;
  logic          w_frame_wrap;

  assign w_pix_step   = i_run && (r_div == DW'(CLK_DIV - 1));
  assign w_line_wrap  = w_pix_step && (r_h == HW'(HT - 1));
  assign w_frame_wrap = w_line_wrap && (r_v == VW'(VT - 1));

  // Dropping i_run clears everything so the next start is always at pixel (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!i_run) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_pix_step ? '0 : r_div + 1'b1;
      if (w_pix_step)
        r_h <= w_line_wrap ? '0 : r_h + 1'b1;
      if (w_line_wrap)
        r_v <= w_frame_wrap ? '0 : r_v + 1'b1;
    end
  end

  assign o_div        = r_div;
  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_frame_wrap = w_frame_wrap;

endmodule

// File: rtl/fb_scan_ctrl.sv
// Video scan controller: arms on camera start-of-frame, then emits sync/de and frame-buffer reads.
module fb_scan_ctrl
  import fb_scan_ctrl_pkg::*;
#(
  parameter int   CLK_DIV   = VID_CLK_DIV,
  parameter int   H_ACTIVE  = VID_H_ACTIVE,
  parameter int   H_FP      = VID_H_FP,
  parameter int   H_SYNC    = VID_H_SYNC,
  parameter int   H_BP      = VID_H_BP,
  parameter int   V_ACTIVE  = VID_V_ACTIVE,
  parameter int   V_FP      = VID_V_FP,
  parameter int   V_SYNC    = VID_V_SYNC,
  parameter int   V_BP      = VID_V_BP,
  parameter int   IMG_LINES = VID_IMG_LINES,
  parameter logic SYNC_POL  = VID_SYNC_POL,
  parameter int   AW        = VID_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cam_sof,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          img_on,
  output logic          frame_on,
  output logic          mem_rd,
  output logic [AW-1:0] rd_addr,
  output logic [7:0]    frame_cnt,
  output logic          running
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam logic [AW-1:0] ADDR_MAX = AW'(IMG_LINES * H_ACTIVE - 1);

  scan_state_t   r_state;
  scan_state_t   w_state_next;
  logic [DW-1:0] w_div;
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic [15:0]   w_h16;
  logic [15:0]   w_v16;
  logic          w_frame_wrap;
  logic          w_cnt_run;
  logic          w_run_st;
  logic          w_de_next;
  logic          w_img_next;
  logic          w_frame_on_next;
  logic          w_hs_act;
  logic          w_vs_act;

  logic          r_pix_ce;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic          r_img_on;
  logic          r_frame_on;
  logic          r_mem_rd;
  logic [AW-1:0] r_rd_addr;
  logic [7:0]    r_frame_cnt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_next = ST_ARM;
      ST_ARM: begin
        if (!en)
          w_state_next = ST_IDLE;
        else if (cam_sof)
          w_state_next = ST_RUN;
      end
      ST_RUN:  if (!en) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  assign w_run_st  = (r_state == ST_RUN);
  assign w_cnt_run = w_run_st && en;

  fb_scan_ctrl_vid_timing_cnt #(
    .CLK_DIV (CLK_DIV),
    .HT      (HT),
    .VT      (VT),
    .DW      (DW),
    .HW      (HW),
    .VW      (VW)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_run        (w_cnt_run),
    .o_div        (w_div),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_frame_wrap (w_frame_wrap)
  );

  // Decode still follows the counters on the disabling edge; outputs drop one clk after.
  assign w_h16           = 16'(w_h);
  assign w_v16           = 16'(w_v);
  assign w_frame_on_next = w_run_st && (w_v16 < 16'(V_ACTIVE));
  assign w_de_next       = w_frame_on_next && (w_h16 < 16'(H_ACTIVE));
  assign w_img_next      = w_de_next && (w_v16 < 16'(IMG_LINES));
  assign w_hs_act        = w_run_st && in_window(w_h16, 16'(H_ACTIVE + H_FP),
                                                 16'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_act        = w_run_st && in_window(w_v16, 16'(V_ACTIVE + V_FP),
                                                 16'(V_ACTIVE + V_FP + V_SYNC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_ce   <= 1'b0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_de       <= 1'b0;
      r_img_on   <= 1'b0;
      r_frame_on <= 1'b0;
      r_mem_rd   <= 1'b0;
    end else begin
      r_pix_ce   <= w_run_st && (w_div == DW'(CLK_DIV - 1));
      r_hsync    <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_de       <= w_de_next;
      r_img_on   <= w_img_next;
      r_frame_on <= w_frame_on_next;
      r_mem_rd   <= w_img_next && (w_div == '0);
    end
  end

  // Pointer clears together with frame_on falling and parks at the last pixel once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rd_addr <= '0;
    else if (!w_frame_on_next)
      r_rd_addr <= '0;
    else if (r_mem_rd && (r_rd_addr != ADDR_MAX))
      r_rd_addr <= r_rd_addr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_frame_cnt <= 8'd0;
    else if (w_frame_wrap)
      r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  assign pix_ce    = r_pix_ce;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;
  assign img_on    = r_img_on;
  assign frame_on  = r_frame_on;
  assign mem_rd    = r_mem_rd;
  assign rd_addr   = r_rd_addr;
  assign frame_cnt = r_frame_cnt;
  assign running   = w_run_st;

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Randomized en/cam_sof stimulus against a scan-position reference model on a shrunken raster.
module tb_fb_scan_ctrl;

  localparam int   CD   = 3;
  localparam int   HA   = 16;
  localparam int   HFP  = 2;
  localparam int   HS   = 4;
  localparam int   HBP  = 3;
  localparam int   VA   = 12;
  localparam int   VFP  = 1;
  localparam int   VS   = 2;
  localparam int   VBP  = 2;
  localparam int   IMG  = 9;
  localparam int   AW   = 12;
  localparam logic POL  = 1'b0;
  localparam logic NPOL = ~POL;
  localparam int   HT   = HA + HFP + HS + HBP;
  localparam int   VT   = VA + VFP + VS + VBP;
  localparam int   FT   = CD * HT * VT;
  localparam int   AMAX = IMG * HA - 1;
  localparam int   NCYC = 40000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cam_sof;
  logic          pix_ce;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          img_on;
  logic          frame_on;
  logic          mem_rd;
  logic [AW-1:0] rd_addr;
  logic [7:0]    frame_cnt;
  logic          running;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 armed, 2 scanning; m_t = clocks elapsed since scan start.
  int         m_mode;
  int         m_t;
  int         m_prev_t;
  logic       m_prev_run;
  logic [7:0] m_frames;
  int         cyc_now;

  logic e_pix, e_de, e_img, e_fon, e_mem, e_hs, e_vs;
  int   e_addr;

  fb_scan_ctrl #(
    .CLK_DIV   (CD),
    .H_ACTIVE  (HA),
    .H_FP      (HFP),
    .H_SYNC    (HS),
    .H_BP      (HBP),
    .V_ACTIVE  (VA),
    .V_FP      (VFP),
    .V_SYNC    (VS),
    .V_BP      (VBP),
    .IMG_LINES (IMG),
    .SYNC_POL  (POL),
    .AW        (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cam_sof   (cam_sof),
    .pix_ce    (pix_ce),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .img_on    (img_on),
    .frame_on  (frame_on),
    .mem_rd    (mem_rd),
    .rd_addr   (rd_addr),
    .frame_cnt (frame_cnt),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc_now, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_t        = 0;
    m_prev_t   = 0;
    m_prev_run = 1'b0;
    m_frames   = 8'd0;
  endtask

  task automatic model_step();
    int old_mode;
    old_mode   = m_mode;
    m_prev_run = (m_mode == 2);
    m_prev_t   = m_t;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) m_mode = 0;
        else if (cam_sof) begin
          m_mode = 2;
          m_t    = 0;
        end
      end
      default: begin
        if (!en) begin
          m_mode = 0;
          m_t    = 0;
        end else begin
          if ((m_t + 1) % FT == 0) m_frames = m_frames + 8'd1;
          m_t++;
        end
      end
    endcase
    if (old_mode != m_mode)
      $display("cyc=%0d mode %0d -> %0d frames=%0d", cyc_now, old_mode, m_mode, m_frames);
  endtask

  // Outputs after an edge describe the scan position held just before that edge.
  task automatic compute_exp();
    int c, ph, n, h, v, cnt;
    if (!m_prev_run) begin
      e_pix = 0; e_de = 0; e_img = 0; e_fon = 0; e_mem = 0;
      e_hs = NPOL; e_vs = NPOL; e_addr = 0;
    end else begin
      c  = m_prev_t % FT;
      ph = c % CD;
      n  = c / CD;
      h  = n % HT;
      v  = n / HT;
      e_fon = (v < VA);
      e_de  = e_fon && (h < HA);
      e_img = e_de && (v < IMG);
      e_mem = e_img && (ph == 0);
      e_pix = (ph == CD - 1);
      e_hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : NPOL;
      e_vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : NPOL;
      if (!e_fon) e_addr = 0;
      else if (v >= IMG) e_addr = AMAX;
      else begin
        cnt = v * HA + ((h < HA) ? h : HA) + ((h < HA && ph > 0) ? 1 : 0);
        e_addr = (cnt > AMAX) ? AMAX : cnt;
      end
    end
  endtask

  task automatic check_outputs();
    compute_exp();
    check_val("running",   32'(running),   32'(m_mode == 2));
    check_val("pix_ce",    32'(pix_ce),    32'(e_pix));
    check_val("de",        32'(de),        32'(e_de));
    check_val("img_on",    32'(img_on),    32'(e_img));
    check_val("frame_on",  32'(frame_on),  32'(e_fon));
    check_val("mem_rd",    32'(mem_rd),    32'(e_mem));
    check_val("hsync",     32'(hsync),     32'(e_hs));
    check_val("vsync",     32'(vsync),     32'(e_vs));
    check_val("rd_addr",   32'(rd_addr),   32'(e_addr));
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_frames));
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_running"},  32'(running),   32'd0);
    check_val({tag, "_pix_ce"},   32'(pix_ce),    32'd0);
    check_val({tag, "_de"},       32'(de),        32'd0);
    check_val({tag, "_img_on"},   32'(img_on),    32'd0);
    check_val({tag, "_frame_on"}, 32'(frame_on),  32'd0);
    check_val({tag, "_mem_rd"},   32'(mem_rd),    32'd0);
    check_val({tag, "_hsync"},    32'(hsync),     32'(NPOL));
    check_val({tag, "_vsync"},    32'(vsync),     32'(NPOL));
    check_val({tag, "_rd_addr"},  32'(rd_addr),   32'd0);
    check_val({tag, "_frame_cnt"},32'(frame_cnt), 32'd0);
  endtask

  initial begin
    int n_resets;
    n_resets = 0;
    cyc_now  = 0;
    rst      = 1'b1;
    en       = 1'b0;
    cam_sof  = 1'b0;
    model_reset();
    #1;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC && bad < 100; cyc++) begin
      @(negedge clk);
      cyc_now = cyc;
      check_outputs();

      if (m_mode == 2 && ((cyc > 15000 && n_resets == 0) || (cyc > 30000 && n_resets == 1))) begin
        cam_sof = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_resets++;
        $display("cyc=%0d async reset applied mid-scan", cyc);
      end

      if (en) begin
        if ($urandom_range(0, (m_mode == 1) ? 399 : 5999) == 0) en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
      end
      cam_sof = ($urandom_range(0, 299) == 0);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_scan_ctrl.md
# fb_scan_ctrl

Video timing and frame-buffer read scheduler for the HDMI output path. Divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. Generates sync, data-enable and the per-pixel memory-read strobe and address that step the frame buffer out to the encoder. Display starts only after the camera has begun writing a frame, so the first displayed frame is never stale power-up memory.

## Interface
- CLK_DIV, 5: system clocks per pixel (≥3)
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing, pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing, lines
- IMG_LINES, 400: active lines backed by the buffer; lines IMG_LINES..V_ACTIVE-1 are blanked to black (de high, mem_rd low)
- SYNC_POL, 0: sync active level
- AW, 20: read-address width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  level; scan runs while high
- cam_sof  in  1  one-clk pulse, camera start-of-frame (valid && tuser)
- pix_ce  out  1  one-clk pulse per pixel period
- hsync  out  1  horizontal sync, SYNC_POL when active
- vsync  out  1  vertical sync, SYNC_POL when active
- de  out  1  active-video window
- img_on  out  1  de and line < IMG_LINES (selects buffer data vs black)
- frame_on  out  1  low from first vblank line to end of frame; buffer read pointer clears while low
- mem_rd  out  1  one-clk strobe: consume pixel at rd_addr
- rd_addr  out  AW  buffer read address
- frame_cnt  out  8  displayed-frame counter, wraps 255→0
- running  out  1  FSM in RUN

## Operation
- FSM states: IDLE, ARM, RUN. Reset → IDLE.
- IDLE: counters held at 0, outputs inactive. en=1 → ARM.
- ARM: wait for cam_sof. cam_sof=1 → RUN, with div/h/v counters at 0.
- RUN: counters free-run. en=0 → IDLE on next edge. All outputs go inactive one clk later. Counters clear.
- en=0 in ARM → IDLE. cam_sof in IDLE or RUN is ignored.
- div_cnt 0..CLK_DIV-1. Pixel step occurs when div_cnt==CLK_DIV-1.
- h_cnt 0..HT-1, with HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800). Wraps to 0 and steps v_cnt.
- v_cnt 0..VT-1, with VT=525. Wraps to 0 and increments frame_cnt.
- Active region: h_cnt < H_ACTIVE, and v_cnt < V_ACTIVE.
- hsync active: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync active: the same form on v_cnt.
- frame_on = (v_cnt < V_ACTIVE).
- mem_rd pulses once per img_on pixel.
- rd_addr: cleared to 0 while frame_on=0. Increments by 1 the clk after each mem_rd.
- rd_addr saturates at IMG_LINES*H_ACTIVE-1 (255999) and never wraps mid-frame.

## Timing
- Reset values: pix_ce, de, img_on, frame_on, mem_rd, running = 0. hsync = vsync = !SYNC_POL. rd_addr = 0. frame_cnt = 0. FSM = IDLE.
- Entry into RUN at edge E:
  - First pix_ce at E+CLK_DIV.
  - Pixel (0,0) outputs appear at E+1: de=img_on=frame_on=1, mem_rd=1, rd_addr=0.
- Decoded outputs are registered from the counters. They change exactly one clk after a counter update and hold for CLK_DIV clks.
- mem_rd is high on the first clk of each pixel period only.
- Read-data latency budget: downstream has CLK_DIV-1 clks after mem_rd. It samples on pix_ce.
- frame_cnt increments on the edge where v_cnt wraps.
- rst asserted at any time: all outputs take reset values immediately (async). No partial frame resumes.

## Structure
- Shared video package holds the 640x480@60 timing constants, CLK_DIV, and the FSM state enum (IDLE/ARM/RUN).
- One sub-module is natural: vid_timing_cnt (div/h/v counters plus wrap pulses). fb_scan_ctrl adds the FSM, decode and address generation.

## Test plan
- Reset: assert rst mid-RUN → all outputs at reset values in the same cycle. running=0 after release.
- Arming: en=1, no cam_sof for 10k clks → running=0, de never high. cam_sof pulse → running=1 next clk, de=1 one clk later.
- Line timing: in RUN, measure → hsync period 4000 clks, active width 480 clks, de width 3200 clks, hsync starts 3280 clks after de rise.
- Frame/address: one full frame → exactly 256000 mem_rd pulses. Last rd_addr=255999. rd_addr=0 once frame_on falls. Lines 400..479 have de=1, img_on=0. frame_cnt +1 per 2,100,000 clks.
- Disable mid-line: en=0 at h_cnt=300 → running=0 next clk, outputs inactive one clk later. Re-enable → returns to ARM, waits for cam_sof.
- Stray cam_sof during RUN at v_cnt=200 → no change to counters, rd_addr or frame_cnt.
